// File: rtl/seq_divider_32_if.sv
// ---------------------------------------------------------------------------
// seq_divider_32_if
//
// Purpose : groups the start/busy/done handshake and the operand/result
//           buses between the ALU control sequencer and seq_divider_32.
//
// Signals :
//   start        sequencer -> divider  request, honoured only when busy=0
//   signed_op    sequencer -> divider  two's-complement request
//   dividend     sequencer -> divider  32-bit dividend
//   divisor      sequencer -> divider  32-bit divisor
//   busy         divider -> sequencer  division in progress
//   done         divider -> sequencer  one-cycle result-update pulse
//   div_by_zero  divider -> sequencer  last accepted divisor was zero
//   quotient     divider -> sequencer  result, held between done pulses
//   remainder    divider -> sequencer  result, held between done pulses
//
// Modports: master = sequencer side, slave = divider side.
// ---------------------------------------------------------------------------
interface seq_divider_32_if;

   logic        start;
   logic        signed_op;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] quotient;
   logic [31:0] remainder;

   modport master (
      output start, signed_op, dividend, divisor,
      input  busy, done, div_by_zero, quotient, remainder
   );

   modport slave (
      input  start, signed_op, dividend, divisor,
      output busy, done, div_by_zero, quotient, remainder
   );

endinterface

// File: rtl/seq_divider_32.sv
// ---------------------------------------------------------------------------
// seq_divider_32
//
// Purpose : multi-cycle 32-bit restoring divider. One quotient bit is
//           produced per clock using a single full_subtractor_32 as the
//           trial-subtract datapath.
//
// Ports   :
//   clk    input   system clock, rising edge
//   rst_n  input   asynchronous active-low reset
//   bus    seq_divider_32_if.slave  handshake, operands and results
//
// Parameters:
//   WIDTH  operand width, must be 32 (matches full_subtractor_32)
//
// Configuration macro:
//   SIGNED_DIV_EN  when defined, signed_op=1 requests two's-complement
//                  division; a FIXUP state applies the result signs and
//                  latency grows from 33 to 34 cycles. When undefined,
//                  signed_op is ignored and all divisions are unsigned.
//
// Latency (start accepted at edge k):
//   normal        done after edge k+33 (k+34 with SIGNED_DIV_EN)
//   divisor == 0  done after edge k+2
// ---------------------------------------------------------------------------

// 32-bit ripple-style subtractor: diff = x - y - bin, bout = borrow out.
module full_subtractor_32 (
   input  logic [31:0] x_i,
   input  logic [31:0] y_i,
   input  logic        bin_i,
   output logic [31:0] diff_o,
   output logic        bout_o
);

   // A 33-bit subtraction: the top bit of the wrapped result is the borrow.
   assign {bout_o, diff_o} = {1'b0, x_i} - {1'b0, y_i} - {32'd0, bin_i};

endmodule

module seq_divider_32 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   seq_divider_32_if.slave  bus
);

   // The datapath is hard-wired to the 32-bit subtractor.
   if (WIDTH != 32) begin : gWidthCheck
      $error("seq_divider_32: WIDTH must be 32");
   end

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      ZERO  = 3'd2,
      FIXUP = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  count_q, count_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] dq_q, dq_d;
   logic [31:0] divisor_q, divisor_d;
   logic [31:0] dividendRaw_q, dividendRaw_d;
   logic [31:0] quotient_q, quotient_d;
   logic [31:0] remainder_q, remainder_d;
   logic        divByZero_q, divByZero_d;

   logic [31:0] dividendMag;
   logic [31:0] divisorMag;

   logic [31:0] trialX;
   logic [31:0] trialDiff;
   logic        trialBout;
   logic        trialAccept;
   logic [31:0] iterRem;
   logic [31:0] iterDq;

`ifdef SIGNED_DIV_EN
   logic        negQuot_q, negQuot_d;
   logic        negRem_q, negRem_d;
   logic        dividendNeg;
   logic        divisorNeg;

   // Operands become magnitudes; the signs are remembered for FIXUP.
   assign dividendNeg = bus.signed_op & bus.dividend[31];
   assign divisorNeg  = bus.signed_op & bus.divisor[31];
   assign dividendMag = dividendNeg ? (32'd0 - bus.dividend) : bus.dividend;
   assign divisorMag  = divisorNeg  ? (32'd0 - bus.divisor)  : bus.divisor;
`else
   logic        unusedSignedOp;

   assign unusedSignedOp = bus.signed_op;
   assign dividendMag    = bus.dividend;
   assign divisorMag     = bus.divisor;
`endif

   // Trial subtract of the shifted partial remainder {rem, dq[31]}; bit 32
   // of that shifted value is rem_q[31], which forces acceptance because
   // the 33-bit value is then certainly larger than any 32-bit divisor.
   assign trialX      = {rem_q[30:0], dq_q[31]};
   assign trialAccept = rem_q[31] | ~trialBout;
   assign iterRem     = trialAccept ? trialDiff : trialX;
   assign iterDq      = {dq_q[30:0], trialAccept};

   full_subtractor_32 uTrialSub (
      .x_i    (trialX),
      .y_i    (divisor_q),
      .bin_i  (1'b0),
      .diff_o (trialDiff),
      .bout_o (trialBout)
   );

   // Next-state and handshake decode. RUN spends 32 edges iterating and one
   // more edge committing (or handing over to FIXUP); ZERO likewise holds
   // for one settle edge before its commit edge.
   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      rem_d         = rem_q;
      dq_d          = dq_q;
      divisor_d     = divisor_q;
      dividendRaw_d = dividendRaw_q;
      quotient_d    = quotient_q;
      remainder_d   = remainder_q;
      divByZero_d   = divByZero_q;
`ifdef SIGNED_DIV_EN
      negQuot_d     = negQuot_q;
      negRem_d      = negRem_q;
`endif
      bus.busy      = 1'b0;
      bus.done      = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            bus.done = (state_q == DONE);
            state_d  = IDLE;
            if (bus.start) begin
               dividendRaw_d = bus.dividend;
               divisor_d     = divisorMag;
               dq_d          = dividendMag;
               rem_d         = 32'd0;
               count_d       = 6'd0;
               divByZero_d   = 1'b0;
`ifdef SIGNED_DIV_EN
               negQuot_d     = dividendNeg ^ divisorNeg;
               negRem_d      = dividendNeg;
`endif
               state_d       = (bus.divisor == 32'd0) ? ZERO : RUN;
            end
         end

         RUN: begin
            bus.busy = 1'b1;
            if (count_q == 6'd32) begin
`ifdef SIGNED_DIV_EN
               state_d     = FIXUP;
`else
               quotient_d  = dq_q;
               remainder_d = rem_q;
               state_d     = DONE;
`endif
            end else begin
               rem_d   = iterRem;
               dq_d    = iterDq;
               count_d = count_q + 6'd1;
            end
         end

         ZERO: begin
            bus.busy = 1'b1;
            if (count_q == 6'd1) begin
               quotient_d  = 32'hFFFF_FFFF;
               remainder_d = dividendRaw_q;
               divByZero_d = 1'b1;
               state_d     = DONE;
            end else begin
               count_d = count_q + 6'd1;
            end
         end

         FIXUP: begin
            bus.busy    = 1'b1;
            quotient_d  = dq_q;
            remainder_d = rem_q;
`ifdef SIGNED_DIV_EN
            // Quotient sign follows the operand signs, remainder follows
            // the dividend; -2^31 / -1 wraps back to 32'h80000000.
            if (negQuot_q) quotient_d  = 32'd0 - dq_q;
            if (negRem_q)  remainder_d = 32'd0 - rem_q;
`endif
            state_d     = DONE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset clears everything so an aborted
   // division leaves no trace and never produces a done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         count_q       <= 6'd0;
         rem_q         <= 32'd0;
         dq_q          <= 32'd0;
         divisor_q     <= 32'd0;
         dividendRaw_q <= 32'd0;
         quotient_q    <= 32'd0;
         remainder_q   <= 32'd0;
         divByZero_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
         negQuot_q     <= 1'b0;
         negRem_q      <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         rem_q         <= rem_d;
         dq_q          <= dq_d;
         divisor_q     <= divisor_d;
         dividendRaw_q <= dividendRaw_d;
         quotient_q    <= quotient_d;
         remainder_q   <= remainder_d;
         divByZero_q   <= divByZero_d;
`ifdef SIGNED_DIV_EN
         negQuot_q     <= negQuot_d;
         negRem_q      <= negRem_d;
`endif
      end
   end

   assign bus.quotient    = quotient_q;
   assign bus.remainder   = remainder_q;
   assign bus.div_by_zero = divByZero_q;

endmodule

// File: tb/tb_seq_divider_32.sv
// ---------------------------------------------------------------------------
// tb_seq_divider_32
//
// Self-checking bench for seq_divider_32: a table of directed vectors run
// back-to-back, hand-written sequences for handshake corner cases (held
// outputs, ignored start while busy, asynchronous reset mid-division) and
// randomized operations checked against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_seq_divider_32;

`ifdef SIGNED_DIV_EN
   localparam bit SIGNED_BUILD = 1'b1;
`else
   localparam bit SIGNED_BUILD = 1'b0;
`endif

   localparam int TIMEOUT = 100;

   typedef struct {
      logic [31:0] dvd;
      logic [31:0] dvs;
      bit          sop;
      logic [31:0] q;
      logic [31:0] r;
      bit          z;
   } vec_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   seq_divider_32_if bus ();

   seq_divider_32 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: plain arithmetic on 64-bit magnitudes
   function automatic void refDiv(input logic [31:0] a, input logic [31:0] b,
                                  input bit s, output logic [31:0] q,
                                  output logic [31:0] r, output bit z);
      longint unsigned ma, mb;
      bit na, nb;
      z = (b == 32'd0);
      if (z) begin
         q = 32'hFFFF_FFFF;
         r = a;
         return;
      end
      na = SIGNED_BUILD & s & a[31];
      nb = SIGNED_BUILD & s & b[31];
      ma = na ? (64'h1_0000_0000 - 64'(a)) : 64'(a);
      mb = nb ? (64'h1_0000_0000 - 64'(b)) : 64'(b);
      q  = 32'(ma / mb);
      r  = 32'(ma % mb);
      if (na ^ nb) q = 32'd0 - q;
      if (na)      r = 32'd0 - r;
   endfunction

   function automatic int expLatency(input logic [31:0] b);
      if (b == 32'd0) return 2;
      return SIGNED_BUILD ? 34 : 33;
   endfunction

   task automatic checkVal(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkInt(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive a one-cycle start; called at a negedge, returns at the negedge
   // after the accepting edge.
   task automatic applyStimulus(input logic [31:0] dvd, input logic [31:0] dvs,
                                input bit sop);
      bus.dividend  = dvd;
      bus.divisor   = dvs;
      bus.signed_op = sop;
      bus.start     = 1'b1;
      @(negedge clk);
      bus.start     = 1'b0;
   endtask

   // Count edges until done is seen, bounded by TIMEOUT
   task automatic waitDone(output int n);
      n = 0;
      while (bus.done !== 1'b1 && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] q,
                              input logic [31:0] r, input bit z,
                              input int lat, input int n);
      checkInt({name, " latency"}, n, lat);
      checkVal({name, " quotient"}, bus.quotient, q);
      checkVal({name, " remainder"}, bus.remainder, r);
      checkVal({name, " div_by_zero"}, {31'd0, bus.div_by_zero}, {31'd0, z});
   endtask

   initial begin
      vec_t        vecs[9];
      int          n;
      int          doneSeen;
      logic [31:0] eq, er, a, b, prevQ, prevR;
      bit          ez, s;

      checks = 0;
      errors = 0;

      vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
      vecs[1] = '{32'hFFFF_FFFF,  32'h0000_0001,  1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0};
      vecs[2] = '{32'hE9EE_C208,  32'h583B_D1CC,  1'b0, 32'd2,          32'h3977_1E70,  1'b0};
      vecs[3] = '{32'h0000_1234,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h0000_1234,  1'b1};
      vecs[4] = '{32'd5,          32'd9,          1'b0, 32'd0,          32'd5,          1'b0};
      vecs[5] = '{32'd0,          32'd9,          1'b0, 32'd0,          32'd0,          1'b0};
`ifdef SIGNED_DIV_EN
      vecs[6] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
      vecs[7] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0};
      vecs[8] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0};
`else
      vecs[6] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'h7FFF_FFFC,  32'd1,          1'b0};
      vecs[7] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'd0,          32'h8000_0000,  1'b0};
      vecs[8] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'd0,          32'd7,          1'b0};
`endif

      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.signed_op = 1'b0;
      bus.dividend  = 32'd0;
      bus.divisor   = 32'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset state
      checkVal("reset busy", {31'd0, bus.busy}, 32'd0);
      checkVal("reset done", {31'd0, bus.done}, 32'd0);
      checkVal("reset div_by_zero", {31'd0, bus.div_by_zero}, 32'd0);
      checkVal("reset quotient", bus.quotient, 32'd0);
      checkVal("reset remainder", bus.remainder, 32'd0);

      // Directed table, each start issued in the previous done cycle
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].dvd, vecs[i].dvs, vecs[i].sop);
         if (i == 0) checkVal("busy after accept", {31'd0, bus.busy}, 32'd1);
         waitDone(n);
         checkOutput($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].z,
                     expLatency(vecs[i].dvs), n);
      end
      prevQ = vecs[8].q;
      prevR = vecs[8].r;

      // done is a single-cycle pulse and results stay put afterwards
      @(negedge clk);
      checkVal("done width", {31'd0, bus.done}, 32'd0);
      checkVal("idle busy", {31'd0, bus.busy}, 32'd0);
      checkVal("idle hold quotient", bus.quotient, prevQ);

      // Results held during a following RUN; a start while busy is ignored
      applyStimulus(32'd1000, 32'd3, 1'b0);
      repeat (5) @(negedge clk);
      checkVal("hold quotient in run", bus.quotient, prevQ);
      checkVal("hold remainder in run", bus.remainder, prevR);
      bus.dividend = 32'd50;
      bus.divisor  = 32'd5;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start    = 1'b0;
      waitDone(n);
      checkOutput("ignored start", 32'd333, 32'd1, 1'b0, expLatency(32'd3) - 6, n);

      // Asynchronous reset during RUN iteration 10
      applyStimulus(32'd100, 32'd7, 1'b0);
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkVal("async rst busy", {31'd0, bus.busy}, 32'd0);
      checkVal("async rst done", {31'd0, bus.done}, 32'd0);
      checkVal("async rst quotient", bus.quotient, 32'd0);
      checkVal("async rst remainder", bus.remainder, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      doneSeen = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.done === 1'b1 || bus.busy === 1'b1) doneSeen++;
      end
      checkInt("no done after abort", doneSeen, 0);

      // Randomized operations against the reference model
      for (int i = 0; i < 24; i++) begin
         a = $urandom;
         case ($urandom_range(0, 4))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 255));
            2:       b = a + 32'($urandom_range(1, 16));
            default: b = $urandom;
         endcase
         s = 1'($urandom_range(0, 1));
         refDiv(a, b, s, eq, er, ez);
         applyStimulus(a, b, s);
         waitDone(n);
         checkOutput($sformatf("rand%0d %h/%h s%0d", i, a, b, s), eq, er, ez,
                     expLatency(b), n);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
